// File: rtl/phy_test_pkg.sv
// Shared defaults, state/mode encodings and the LFSR step for the PHY loopback sequencer.
package phy_test_pkg;

  localparam int DEF_LANES   = 16;
  localparam int DEF_LANE_W  = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef enum logic {
    PAT_INC  = 1'b0,
    PAT_LFSR = 1'b1
  } pat_mode_t;

  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: bits 7,5,4,3 feed bit 0
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/phy_test_pattern_gen.sv
// One-beat pattern source: a per-beat base byte, fanned out to lanes as base+l or base^l.
module phy_test_pattern_gen
  import phy_test_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_init,
  input  logic                    i_mode,
  input  logic [LANE_W-1:0]       i_seed,
  input  logic                    i_adv,
  output logic [LANES*LANE_W-1:0] o_beat
);

  pat_mode_t         r_mode;
  logic [LANE_W-1:0] r_base;

  // Latch seed/mode on init (zero seed would lock the LFSR), step the base on each advance
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mode <= PAT_INC;
      r_base <= '0;
    end else if (i_init) begin
      r_mode <= pat_mode_t'(i_mode);
      r_base <= (i_mode && (i_seed == '0)) ? LANE_W'(1) : i_seed;
    end else if (i_adv) begin
      r_base <= (r_mode == PAT_LFSR) ? lfsr_step(r_base) : r_base + LANE_W'(1);
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign o_beat[l*LANE_W +: LANE_W] = (r_mode == PAT_LFSR) ? (r_base ^ LANE_W'(l))
                                                             : (r_base + LANE_W'(l));
  end

endmodule

// File: rtl/phy_test_sequencer.sv
// PHY loopback test sequencer: sends N pattern beats, checks N looped-back beats per lane.
module phy_test_sequencer
  import phy_test_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int LANE_W  = DEF_LANE_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_mode,
  input  logic [LANE_W-1:0]       i_seed,
  input  logic [CNT_W-1:0]        i_num_beats,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic [LANES*LANE_W-1:0] o_tx_data,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  input  logic [LANES*LANE_W-1:0] i_rx_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_timed_out,
  output logic [CNT_W-1:0]        o_err_count,
  output logic [LANES-1:0]        o_err_lane_mask,
  output logic [CNT_W-1:0]        o_rx_beats
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam int MC_W = $clog2(LANES + 1);

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0] r_num_beats, r_tx_cnt, r_rx_beats, r_err_count;
  logic [LANES-1:0] r_mask;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_tx_valid, r_done, r_pass, r_timed_out;

  logic                    w_start, w_tx_hs, w_rx_hs, w_rx_last, w_to_hit;
  logic [LANES*LANE_W-1:0] w_tx_beat, w_rx_exp;
  logic [LANES-1:0]        w_mis;
  logic [MC_W-1:0]         w_mis_cnt;
  logic [CNT_W:0]          w_err_sum;
  logic [CNT_W-1:0]        w_err_nxt;

  assign w_start    = (r_state == ST_IDLE) && i_start;
  assign w_tx_hs    = r_tx_valid && i_tx_ready;
  // Outside RUN the port stays ready so stray beats drain instead of backing up the PHY
  assign o_rx_ready = (r_state != ST_RUN) || (r_rx_beats < r_num_beats);
  assign w_rx_hs    = (r_state == ST_RUN) && i_rx_valid && o_rx_ready;
  assign w_rx_last  = w_rx_hs && (r_rx_beats == r_num_beats - CNT_W'(1));
  assign w_to_hit   = (r_state == ST_RUN) && !w_tx_hs && !w_rx_hs &&
                      (r_to_cnt == TO_W'(TIMEOUT - 1));

  phy_test_pattern_gen #(.LANES(LANES), .LANE_W(LANE_W)) u_tx_gen (
    .i_clk   (i_clock),
    .i_rst_n (i_reset),
    .i_init  (w_start),
    .i_mode  (i_mode),
    .i_seed  (i_seed),
    .i_adv   (w_tx_hs),
    .o_beat  (w_tx_beat)
  );

  phy_test_pattern_gen #(.LANES(LANES), .LANE_W(LANE_W)) u_rx_gen (
    .i_clk   (i_clock),
    .i_rst_n (i_reset),
    .i_init  (w_start),
    .i_mode  (i_mode),
    .i_seed  (i_seed),
    .i_adv   (w_rx_hs),
    .o_beat  (w_rx_exp)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_cmp
    assign w_mis[l] = i_rx_data[l*LANE_W +: LANE_W] != w_rx_exp[l*LANE_W +: LANE_W];
  end

  // Count mismatching lanes on this beat and form the saturated error total
  always_comb begin
    w_mis_cnt = '0;
    for (int l = 0; l < LANES; l++) w_mis_cnt = w_mis_cnt + MC_W'(w_mis[l]);
    w_err_sum = {1'b0, r_err_count} + (CNT_W+1)'(w_mis_cnt);
    w_err_nxt = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
  end

  // FSM state register
  always_ff @(posedge i_clock) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state: FIN lasts one cycle, then back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = (i_num_beats == '0) ? ST_FIN : ST_RUN;
      ST_RUN:  if (w_rx_last || w_to_hit) w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: TX/RX counters, compare results, timeout and end-of-test flags
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_num_beats <= '0;
      r_tx_cnt    <= '0;
      r_rx_beats  <= '0;
      r_err_count <= '0;
      r_mask      <= '0;
      r_to_cnt    <= '0;
      r_tx_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_num_beats <= i_num_beats;
        r_tx_cnt    <= '0;
        r_rx_beats  <= '0;
        r_err_count <= '0;
        r_mask      <= '0;
        r_to_cnt    <= '0;
        r_timed_out <= 1'b0;
        r_tx_valid  <= (i_num_beats != '0);
        r_pass      <= (i_num_beats == '0);
        r_done      <= (i_num_beats == '0);
      end
      if (r_state == ST_RUN) begin
        if (w_tx_hs) begin
          r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          if (r_tx_cnt == r_num_beats - CNT_W'(1)) r_tx_valid <= 1'b0;
        end
        if (w_rx_hs) begin
          r_err_count <= w_err_nxt;
          r_mask      <= r_mask | w_mis;
          r_rx_beats  <= r_rx_beats + CNT_W'(1);
        end
        if (w_tx_hs || w_rx_hs) r_to_cnt <= '0;
        else if (!w_to_hit)     r_to_cnt <= r_to_cnt + TO_W'(1);
        if (w_rx_last) begin
          r_done     <= 1'b1;
          r_pass     <= (w_err_nxt == '0);
          r_tx_valid <= 1'b0;
        end
        if (w_to_hit) begin
          // Abort: dropping tx_valid mid-beat is tolerated only here
          r_done      <= 1'b1;
          r_pass      <= 1'b0;
          r_timed_out <= 1'b1;
          r_tx_valid  <= 1'b0;
        end
      end
    end
  end

  assign o_tx_valid      = r_tx_valid;
  assign o_tx_data       = r_tx_valid ? w_tx_beat : '0;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_timed_out     = r_timed_out;
  assign o_err_count     = r_err_count;
  assign o_err_lane_mask = r_mask;
  assign o_rx_beats      = r_rx_beats;

endmodule

// File: tb/tb_phy_test_sequencer.sv
// Loopback bench: expected TX beats queued at start, looped beats queued on TX, drained on RX.
module tb_phy_test_sequencer;
  localparam int LANES = 16;
  localparam int DW    = 128;

  logic          clk = 1'b0;
  logic          i_reset, i_start, i_mode, i_tx_ready, i_rx_valid;
  logic [7:0]    i_seed;
  logic [15:0]   i_num_beats;
  logic [DW-1:0] i_rx_data;
  logic          o_tx_valid, o_rx_ready, o_busy, o_done, o_pass, o_timed_out;
  logic [DW-1:0] o_tx_data;
  logic [15:0]   o_err_count, o_err_lane_mask, o_rx_beats;

  always #5 clk = ~clk;

  phy_test_sequencer dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_mode(i_mode),
    .i_seed(i_seed), .i_num_beats(i_num_beats),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data),
    .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready), .i_rx_data(i_rx_data),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timed_out(o_timed_out),
    .o_err_count(o_err_count), .o_err_lane_mask(o_err_lane_mask), .o_rx_beats(o_rx_beats)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] lb_q[$];
  logic [DW-1:0] corr[16];
  logic [DW-1:0] stall_data;
  bit            lb_en, toggle_rdy, stall_prev, done_seen;
  int            cyc_n, tx_hs_n, rx_hs_n, last_rx_cyc, done_cyc, poke_at;
  logic          s_pass, s_to;
  logic [15:0]   s_err, s_mask, s_rxb;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_beat(input logic m, input logic [7:0] s, input int k);
    logic [7:0]    b;
    logic [DW-1:0] r;
    b = (m && s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < k; i++) b = m ? {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]} : b + 8'd1;
    for (int l = 0; l < LANES; l++) r[l*8 +: 8] = m ? (b ^ 8'(l)) : (b + 8'(l));
    return r;
  endfunction

  // One cycle: check held beat, snapshot done, drive inputs, score handshakes at next edge
  task automatic cyc();
    logic [DW-1:0] c;
    @(negedge clk);
    cyc_n++;
    i_start = 1'b0;
    if (poke_at == cyc_n) begin
      i_start = 1'b1; i_num_beats = 16'd9; i_seed = 8'h77;
    end
    if (stall_prev) begin
      chk("tx_hold_valid", DW'(o_tx_valid), 1);
      chk("tx_hold_data", o_tx_data, stall_data);
    end
    if (o_done && !done_seen) begin
      done_seen = 1; done_cyc = cyc_n;
      s_pass = o_pass; s_to = o_timed_out; s_err = o_err_count;
      s_mask = o_err_lane_mask; s_rxb = o_rx_beats;
    end
    i_tx_ready = toggle_rdy ? ~i_tx_ready : 1'b1;
    i_rx_valid = lb_en && (lb_q.size() > 0);
    i_rx_data  = i_rx_valid ? lb_q[0] : '0;
    if (o_tx_valid && i_tx_ready) begin
      if (exp_q.size() == 0) chk("tx_extra_beats", DW'(exp_q.size()), 1);
      else                   chk("tx_data", o_tx_data, exp_q.pop_front());
      c = (tx_hs_n < 16) ? corr[tx_hs_n] : '0;
      lb_q.push_back(o_tx_data ^ c);
      tx_hs_n++;
    end
    stall_prev = o_tx_valid && !i_tx_ready;
    stall_data = o_tx_data;
    if (i_rx_valid && o_rx_ready) begin
      void'(lb_q.pop_front());
      rx_hs_n++; last_rx_cyc = cyc_n;
    end
  endtask

  task automatic start_test(input logic m, input logic [7:0] s, input int nb);
    exp_q.delete(); lb_q.delete();
    for (int i = 0; i < 16; i++) corr[i] = '0;
    tx_hs_n = 0; rx_hs_n = 0; cyc_n = 0; last_rx_cyc = -100; done_seen = 0; stall_prev = 0;
    for (int k = 0; k < nb; k++) exp_q.push_back(model_beat(m, s, k));
    @(negedge clk);
    i_start = 1'b1; i_mode = m; i_seed = s; i_num_beats = 16'(nb);
    i_rx_valid = 1'b0; i_tx_ready = toggle_rdy ? 1'b0 : 1'b1;
  endtask

  task automatic run_to_done(input int limit);
    int n = 0;
    while (!done_seen && n < limit) begin cyc(); n++; end
    chk("done_seen", DW'(done_seen), 1);
    cyc();
    chk("done_one_cycle", DW'(o_done), 0);
    chk("idle_not_busy", DW'(o_busy), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tx_valid"}, DW'(o_tx_valid), 0);
    chk({tag, "_tx_data"}, o_tx_data, 0);
    chk({tag, "_busy"}, DW'(o_busy), 0);
    chk({tag, "_done"}, DW'(o_done), 0);
    chk({tag, "_pass"}, DW'(o_pass), 0);
    chk({tag, "_timed_out"}, DW'(o_timed_out), 0);
    chk({tag, "_err"}, DW'(o_err_count), 0);
    chk({tag, "_mask"}, DW'(o_err_lane_mask), 0);
    chk({tag, "_rx_beats"}, DW'(o_rx_beats), 0);
  endtask

  initial begin
    i_reset = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_seed = '0; i_num_beats = '0;
    i_tx_ready = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0;
    lb_en = 1; toggle_rdy = 0; poke_at = -1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    i_reset = 1'b1;

    // Clean incrementing loopback
    start_test(1'b0, 8'h01, 4);
    cyc();
    chk("t1_tx_first_cycle", DW'(tx_hs_n), 1);
    run_to_done(50);
    chk("t1_pass", DW'(s_pass), 1);
    chk("t1_err", DW'(s_err), 0);
    chk("t1_rx_beats", DW'(s_rxb), 4);
    chk("t1_timed_out", DW'(s_to), 0);
    chk("t1_done_after_last_rx", DW'(done_cyc), DW'(last_rx_cyc + 1));
    chk("t1_tx_left", DW'(exp_q.size()), 0);

    // Corrupted lanes: beat 2 lane 3, beat 3 lanes 0 and 15
    start_test(1'b0, 8'h20, 4);
    corr[2] = 128'hFF << 24;
    corr[3] = (128'hFF << 120) | 128'hFF;
    run_to_done(50);
    chk("t2_err", DW'(s_err), 3);
    chk("t2_mask", DW'(s_mask), 128'h8009);
    chk("t2_pass", DW'(s_pass), 0);
    chk("t2_rx_beats", DW'(s_rxb), 4);

    // LFSR with TX stalls every other cycle
    toggle_rdy = 1;
    start_test(1'b1, 8'hA5, 8);
    run_to_done(100);
    chk("t3_pass", DW'(s_pass), 1);
    chk("t3_rx_beats", DW'(s_rxb), 8);
    chk("t3_tx_beats", DW'(tx_hs_n), 8);
    toggle_rdy = 0;

    // No loopback at all: timeout after 4 TX beats plus 1024 idle cycles
    lb_en = 0;
    start_test(1'b0, 8'h03, 4);
    run_to_done(1200);
    chk("t4_done_cycle", DW'(done_cyc), 1029);
    chk("t4_timed_out", DW'(s_to), 1);
    chk("t4_pass", DW'(s_pass), 0);
    chk("t4_rx_beats", DW'(s_rxb), 0);
    chk("t4_tx_beats", DW'(tx_hs_n), 4);
    lb_en = 1;

    // Zero beats: immediate done and pass
    start_test(1'b0, 8'h00, 0);
    run_to_done(5);
    chk("t5_done_cycle", DW'(done_cyc), 1);
    chk("t5_pass", DW'(s_pass), 1);
    chk("t5_no_tx", DW'(tx_hs_n), 0);

    // Start pulsed during RUN is ignored
    start_test(1'b0, 8'h40, 4);
    poke_at = 2;
    run_to_done(50);
    poke_at = -1;
    chk("t5b_rx_beats", DW'(s_rxb), 4);
    chk("t5b_pass", DW'(s_pass), 1);
    chk("t5b_tx_beats", DW'(tx_hs_n), 4);

    // Reset mid-RUN after 2 beats, then a clean rerun
    start_test(1'b0, 8'h10, 8);
    for (int n = 0; n < 20 && tx_hs_n < 2; n++) cyc();
    chk("t6_two_beats", DW'(tx_hs_n), 2);
    @(negedge clk);
    i_reset = 1'b0; i_rx_valid = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    @(negedge clk);
    chk("midreset_no_done", DW'(o_done), 0);
    i_reset = 1'b1;
    start_test(1'b0, 8'h10, 3);
    run_to_done(50);
    chk("t6_pass", DW'(s_pass), 1);
    chk("t6_rx_beats", DW'(s_rxb), 3);
    chk("t6_err", DW'(s_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
